// File: rtl/dcache_ctrl.sv
// dcache_ctrl: request sequencer between one load/store requester, a
// direct-mapped write-back dcache array and a line-granular memory port.
//
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   req_*                 requester request channel (valid/ready)
//   resp_*                requester response channel (valid/ready)
//   cache_*               dcache array lookup / fill / ejection
//   mem_rd_*              memory line read request + returned data
//   mem_wr_*              memory line writeback
//   hit/miss/wb_count_o   saturating performance counters
module dcache_ctrl #(
  parameter int addr_width  = 16,
  parameter int line_width  = 64,
  parameter int count_width = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [addr_width-1:0]  req_addr_i,
  input  logic [line_width-1:0]  req_wdata_i,

  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [line_width-1:0]  resp_data_o,

  output logic [addr_width-1:0]  cache_addr_o,
  output logic                   cache_r_valid_o,
  input  logic                   cache_r_valid_i,
  input  logic                   cache_r_miss_i,
  input  logic [line_width-1:0]  cache_read_i,
  output logic                   cache_w_valid_o,
  output logic                   cache_dirty_o,
  output logic [line_width-1:0]  cache_write_o,
  input  logic                   cache_ej_valid_i,
  input  logic [addr_width-1:0]  cache_ej_addr_i,
  input  logic [line_width-1:0]  cache_ej_data_i,

  output logic                   mem_rd_valid_o,
  input  logic                   mem_rd_ready_i,
  output logic [addr_width-1:0]  mem_rd_addr_o,
  input  logic                   mem_rd_data_valid_i,
  input  logic [line_width-1:0]  mem_rd_data_i,

  output logic                   mem_wr_valid_o,
  input  logic                   mem_wr_ready_i,
  output logic [addr_width-1:0]  mem_wr_addr_o,
  output logic [line_width-1:0]  mem_wr_data_o,

  output logic [count_width-1:0] hit_count_o,
  output logic [count_width-1:0] miss_count_o,
  output logic [count_width-1:0] wb_count_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_FILL,
    S_EJECT,
    S_WB,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [addr_width-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [line_width-1:0]  resp_data_q, resp_data_d;
  logic [line_width-1:0]  fill_data_q, fill_data_d;
  logic                   fill_dirty_q, fill_dirty_d;
  logic [addr_width-1:0]  ej_addr_q, ej_addr_d;
  logic [line_width-1:0]  ej_data_q, ej_data_d;
  logic [count_width-1:0] hit_q, hit_d;
  logic [count_width-1:0] miss_q, miss_d;
  logic [count_width-1:0] wb_q, wb_d;

  // Handshake/strobe outputs are flopped from the next state so that
  // each one is a clean register output tied to exactly one state.
  logic req_ready_q;
  logic resp_valid_q;
  logic cache_r_valid_q;
  logic cache_w_valid_q;
  logic mem_rd_valid_q;
  logic mem_wr_valid_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    resp_data_d  = resp_data_q;
    fill_data_d  = fill_data_q;
    fill_dirty_d = fill_dirty_q;
    ej_addr_d    = ej_addr_q;
    ej_data_d    = ej_data_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    wb_d         = wb_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          if (req_write_i) begin
            // write-allocate: a full-line write goes straight to fill
            fill_data_d  = req_wdata_i;
            fill_dirty_d = 1'b1;
            state_d      = S_FILL;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cache_r_valid_i) begin
          if (!cache_r_miss_i) begin
            resp_data_d = cache_read_i;
            if (hit_q != '1) hit_d = hit_q + 1'b1;
            state_d = S_RESP;
          end else begin
            if (miss_q != '1) miss_d = miss_q + 1'b1;
            state_d = S_FETCH_REQ;
          end
        end
      end
      S_FETCH_REQ: begin
        if (mem_rd_ready_i) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (mem_rd_data_valid_i) begin
          resp_data_d  = mem_rd_data_i;
          fill_data_d  = mem_rd_data_i;
          fill_dirty_d = 1'b0;
          state_d      = S_FILL;
        end
      end
      S_FILL: begin
        state_d = S_EJECT;
      end
      S_EJECT: begin
        if (cache_ej_valid_i) begin
          ej_addr_d = cache_ej_addr_i;
          ej_data_d = cache_ej_data_i;
          state_d   = S_WB;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WB: begin
        if (mem_wr_ready_i) begin
          if (wb_q != '1) wb_d = wb_q + 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      write_q         <= 1'b0;
      resp_data_q     <= '0;
      fill_data_q     <= '0;
      fill_dirty_q    <= 1'b0;
      ej_addr_q       <= '0;
      ej_data_q       <= '0;
      hit_q           <= '0;
      miss_q          <= '0;
      wb_q            <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      cache_r_valid_q <= 1'b0;
      cache_w_valid_q <= 1'b0;
      mem_rd_valid_q  <= 1'b0;
      mem_wr_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      write_q         <= write_d;
      resp_data_q     <= resp_data_d;
      fill_data_q     <= fill_data_d;
      fill_dirty_q    <= fill_dirty_d;
      ej_addr_q       <= ej_addr_d;
      ej_data_q       <= ej_data_d;
      hit_q           <= hit_d;
      miss_q          <= miss_d;
      wb_q            <= wb_d;
      req_ready_q     <= (state_d == S_IDLE);
      resp_valid_q    <= (state_d == S_RESP);
      cache_r_valid_q <= (state_d == S_LOOKUP);
      cache_w_valid_q <= (state_d == S_FILL);
      mem_rd_valid_q  <= (state_d == S_FETCH_REQ);
      mem_wr_valid_q  <= (state_d == S_WB);
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = write_q ? '0 : resp_data_q;

  assign cache_addr_o    = addr_q;
  assign cache_r_valid_o = cache_r_valid_q;
  assign cache_w_valid_o = cache_w_valid_q;
  assign cache_dirty_o   = fill_dirty_q;
  assign cache_write_o   = fill_data_q;

  assign mem_rd_valid_o  = mem_rd_valid_q;
  assign mem_rd_addr_o   = addr_q;
  assign mem_wr_valid_o  = mem_wr_valid_q;
  assign mem_wr_addr_o   = ej_addr_q;
  assign mem_wr_data_o   = ej_data_q;

  assign hit_count_o     = hit_q;
  assign miss_count_o    = miss_q;
  assign wb_count_o      = wb_q;

endmodule
